cond_chain: RTL and testbench

Parametrised successor to the fixed four-instance cond chain. A configurable N-stage datapath: each enabled stage registers the word and XORs it with a key that alternates per accepted word. Stages are linked by valid/ready handshakes with full backpressure and a synchronous flush. The block sits between the input data port and downstream consumers, in place of hand-chained cond instances.

---
 rtl/cond_pkg.sv | 27 ++
 rtl/cond_stage.sv | 60 ++++++
 rtl/cond_chain.sv | 126 ++++++++++++
 tb/tb_cond_chain.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cond_pkg
//  Description : Shared constants and elaboration helpers for the cond chain.
//                Holds the default XOR keys, the supported stage-count limit
//                and a popcount used to size the registered portion of the
//                chain from its stage mask.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
package cond_pkg;

    localparam int          C_MAX_STAGES = 16;
    localparam logic [15:0] C_KEY_A      = 16'h0F0F;
    localparam logic [15:0] C_KEY_B      = 16'hF0F0;

    // Number of registered stages selected by a stage mask.
    function automatic int popcount(input logic [C_MAX_STAGES-1:0] mask);
        int n;
        n = 0;
        for (int i = 0; i < C_MAX_STAGES; i++) begin
            if (mask[i]) n++;
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cond_stage.sv
`default_nettype none
// ============================================================================
//  Module      : cond_stage
//  Description : One registered chain stage. Holds a single word, applies an
//                XOR key that alternates between KEY_A and KEY_B on every
//                word loaded, and exposes valid/ready handshakes on both
//                sides. The stage accepts whenever it is empty or its word is
//                being taken downstream in the same cycle.
//  Ports       : clk, rst        - clock, asynchronous active-high reset
//                i_flush         - synchronous clear of valid and key parity
//                i_in_valid/o_in_ready/i_in_data    - upstream handshake
//                o_out_valid/i_out_ready/o_out_data - downstream handshake
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module cond_stage #(
    parameter int                   DATA_BITS = 16,
    parameter logic [DATA_BITS-1:0] KEY_A     = '0,
    parameter logic [DATA_BITS-1:0] KEY_B     = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_flush,
    input  logic                 i_in_valid,
    output logic                 o_in_ready,
    input  logic [DATA_BITS-1:0] i_in_data,
    output logic                 o_out_valid,
    input  logic                 i_out_ready,
    output logic [DATA_BITS-1:0] o_out_data
);

    logic                 r_valid;
    logic                 r_toggle;
    logic [DATA_BITS-1:0] r_data;

    // Raw acceptance; the chain top adds the flush/reset gating for the
    // external port, flush is resolved inside the register update below.
    assign o_in_ready  = !r_valid || i_out_ready;
    assign o_out_valid = r_valid;
    assign o_out_data  = r_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_toggle <= 1'b0;
            r_data   <= '0;
        end else if (i_flush) begin
            // Data is deliberately kept; only occupancy and key parity clear.
            r_valid  <= 1'b0;
            r_toggle <= 1'b0;
        end else if (o_in_ready) begin
            r_valid <= i_in_valid;
            if (i_in_valid) begin
                r_data   <= i_in_data ^ (r_toggle ? KEY_B : KEY_A);
                r_toggle <= ~r_toggle;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cond_chain.sv
`default_nettype none
// ============================================================================
//  Module      : cond_chain
//  Description : Configurable N-position datapath. Each position whose mask
//                bit is set is a registered XOR stage (cond_stage); cleared
//                bits are pure wire bypasses. Positions are linked by
//                valid/ready with full backpressure; the ready path ripples
//                combinationally back from ib_out_ready. ib_flush empties the
//                chain and restarts the key parity in one cycle.
//  Ports       : ib_clk, ib_rst  - clock, asynchronous active-high reset
//                ib_flush        - synchronous flush
//                ib_in_valid/ob_in_ready/ivG_data   - input handshake
//                ob_out_valid/ib_out_ready/ovG_data - output handshake
//                ovG_count       - saturating count of output handshakes
//  Options     : COND_CHAIN_STATS_EN - build the output handshake counter;
//                without it ovG_count is tied to zero.
//  Limits      : PAR_STAGES must be within 1..16.
//  Revision    : 1.0 - initial parametrised release
// ============================================================================
module cond_chain
    import cond_pkg::*;
#(
    parameter int                       PAR_DATA_BITS  = 16,
    parameter int                       PAR_STAGES     = 4,
    parameter logic [PAR_STAGES-1:0]    PAR_STAGE_MASK = 4'b1111,
    parameter logic [PAR_DATA_BITS-1:0] PAR_XOR_KEY_A  = C_KEY_A,
    parameter logic [PAR_DATA_BITS-1:0] PAR_XOR_KEY_B  = C_KEY_B,
    parameter int                       PAR_CNT_BITS   = 16
) (
    input  logic                     ib_clk,
    input  logic                     ib_rst,
    input  logic                     ib_flush,
    input  logic                     ib_in_valid,
    output logic                     ob_in_ready,
    input  logic [PAR_DATA_BITS-1:0] ivG_data,
    output logic                     ob_out_valid,
    input  logic                     ib_out_ready,
    output logic [PAR_DATA_BITS-1:0] ovG_data,
    output logic [PAR_CNT_BITS-1:0]  ovG_count
);

    localparam int C_NUM_REG = popcount(C_MAX_STAGES'(PAR_STAGE_MASK));

    genvar s;
    generate
        for (s = 0; s < PAR_STAGES; s++) begin : g_pos
            // Word arriving at / leaving this position, and the ready seen
            // on each side of it.
            logic                     w_in_valid;
            logic [PAR_DATA_BITS-1:0] w_in_data;
            logic                     w_in_ready;
            logic                     w_out_valid;
            logic [PAR_DATA_BITS-1:0] w_out_data;
            logic                     w_out_ready;

            if (s == 0) begin : g_head
                assign w_in_valid = ib_in_valid;
                assign w_in_data  = ivG_data;
            end else begin : g_link
                assign w_in_valid = g_pos[s-1].w_out_valid;
                assign w_in_data  = g_pos[s-1].w_out_data;
            end

            if (s == PAR_STAGES - 1) begin : g_tail
                assign w_out_ready = ib_out_ready;
            end else begin : g_next
                assign w_out_ready = g_pos[s+1].w_in_ready;
            end

            if (PAR_STAGE_MASK[s]) begin : g_reg
                cond_stage #(
                    .DATA_BITS (PAR_DATA_BITS),
                    .KEY_A     (PAR_XOR_KEY_A),
                    .KEY_B     (PAR_XOR_KEY_B)
                ) u_stage (
                    .clk         (ib_clk),
                    .rst         (ib_rst),
                    .i_flush     (ib_flush),
                    .i_in_valid  (w_in_valid),
                    .o_in_ready  (w_in_ready),
                    .i_in_data   (w_in_data),
                    .o_out_valid (w_out_valid),
                    .i_out_ready (w_out_ready),
                    .o_out_data  (w_out_data)
                );
            end else begin : g_bypass
                assign w_out_valid = w_in_valid;
                assign w_out_data  = w_in_data;
                assign w_in_ready  = w_out_ready;
            end
        end

        if (C_NUM_REG == 0) begin : g_passthru
            // No storage: flush must refuse the word on both sides at once.
            assign ob_in_ready  = ib_out_ready && !ib_flush;
            assign ob_out_valid = ib_in_valid && !ib_flush;
        end else begin : g_chain
            assign ob_in_ready  = !ib_rst && !ib_flush && g_pos[0].w_in_ready;
            assign ob_out_valid = g_pos[PAR_STAGES-1].w_out_valid;
        end
    endgenerate

    assign ovG_data = g_pos[PAR_STAGES-1].w_out_data;

`ifdef COND_CHAIN_STATS_EN
    logic                    w_take;
    logic [PAR_CNT_BITS-1:0] r_count;

    // A handshake coinciding with flush is overridden and not counted.
    assign w_take = ob_out_valid && ib_out_ready && !ib_flush;

    always_ff @(posedge ib_clk or posedge ib_rst) begin
        if (ib_rst) begin
            r_count <= '0;
        end else if (w_take && (r_count != '1)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign ovG_count = r_count;
`else
    assign ovG_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cond_chain.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cond_chain
//  Description : Self-checking bench for cond_chain. Three instances share
//                clock, reset and flush: a fully registered K=4 chain, a
//                K=3 chain (mask 4'b1011) and a K=0 pass-through with a 4-bit
//                counter. Expected words are queued at input handshakes and
//                compared at output handshakes.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cond_chain;

    localparam logic [15:0] KA = 16'h0F0F;
    localparam logic [15:0] KB = 16'hF0F0;
`ifdef COND_CHAIN_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] data;
        int          cyc;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush;
    logic        v4, ir4, ov4, or4;
    logic [15:0] d4, od4, cnt4;
    logic        v3, ir3, ov3, or3;
    logic [15:0] d3, od3, cnt3;
    logic        v0, ir0, ov0, or0;
    logic [15:0] d0, od0;
    logic [3:0]  cnt0;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          n4, n3, pops4, pops3, idx;
    bit          acc4, acc3, lat_on;
    ent_t        q4[$];
    ent_t        q3[$];
    logic [15:0] log3[$];

    cond_chain #(.PAR_DATA_BITS(16), .PAR_STAGES(4), .PAR_STAGE_MASK(4'b1111),
                 .PAR_XOR_KEY_A(KA), .PAR_XOR_KEY_B(KB), .PAR_CNT_BITS(16)) u_k4 (
        .ib_clk(clk), .ib_rst(rst), .ib_flush(flush), .ib_in_valid(v4), .ob_in_ready(ir4),
        .ivG_data(d4), .ob_out_valid(ov4), .ib_out_ready(or4), .ovG_data(od4), .ovG_count(cnt4));

    cond_chain #(.PAR_DATA_BITS(16), .PAR_STAGES(4), .PAR_STAGE_MASK(4'b1011),
                 .PAR_XOR_KEY_A(KA), .PAR_XOR_KEY_B(KB), .PAR_CNT_BITS(16)) u_k3 (
        .ib_clk(clk), .ib_rst(rst), .ib_flush(flush), .ib_in_valid(v3), .ob_in_ready(ir3),
        .ivG_data(d3), .ob_out_valid(ov3), .ib_out_ready(or3), .ovG_data(od3), .ovG_count(cnt3));

    cond_chain #(.PAR_DATA_BITS(16), .PAR_STAGES(4), .PAR_STAGE_MASK(4'b0000),
                 .PAR_XOR_KEY_A(KA), .PAR_XOR_KEY_B(KB), .PAR_CNT_BITS(4)) u_k0 (
        .ib_clk(clk), .ib_rst(rst), .ib_flush(flush), .ib_in_valid(v0), .ob_in_ready(ir0),
        .ivG_data(d0), .ob_out_valid(ov0), .ib_out_ready(or0), .ovG_data(od0), .ovG_count(cnt0));

    function automatic logic [15:0] exp_key(input int k, input int n);
        if (k % 2 == 0) return 16'h0000;
        return (n % 2 == 0) ? KA : KB;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: sample handshakes at the falling edge, update the
    // scoreboards, then return 1 ns after the next rising edge.
    task automatic tick();
        ent_t e;
        @(negedge clk);
        acc4 = 1'b0;
        acc3 = 1'b0;
        if (flush) begin
            q4.delete(); q3.delete();
            n4 = 0; n3 = 0;
        end else if (!rst) begin
            if (v4 && ir4) begin
                q4.push_back('{data: d4 ^ exp_key(4, n4), cyc: cyc});
                n4++; acc4 = 1'b1;
            end
            if (v3 && ir3) begin
                q3.push_back('{data: d3 ^ exp_key(3, n3), cyc: cyc});
                n3++; acc3 = 1'b1;
            end
            if (ov4 && or4) begin
                chk("k4_out_expected", 32'(q4.size() != 0), 1);
                if (q4.size() != 0) begin
                    e = q4.pop_front();
                    chk("k4_data", od4, e.data);
                    if (lat_on) chk("k4_latency", cyc - e.cyc, 4);
                    pops4++;
                end
            end
            if (ov3 && or3) begin
                chk("k3_out_expected", 32'(q3.size() != 0), 1);
                if (q3.size() != 0) begin
                    e = q3.pop_front();
                    chk("k3_data", od3, e.data);
                    if (lat_on) chk("k3_latency", cyc - e.cyc, 3);
                    log3.push_back(od3);
                    pops3++;
                end
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            if (q4.size() == 0 && q3.size() == 0) break;
            tick();
        end
        chk("drain_k4", q4.size(), 0);
        chk("drain_k3", q3.size(), 0);
    endtask

    task automatic send3(input logic [15:0] w, input int cnt);
        int got;
        got = 0;
        v3 = 1'b1; d3 = w;
        for (int i = 0; i < 20 && got < cnt; i++) begin
            tick();
            if (acc3) got++;
        end
        v3 = 1'b0;
        chk("k3_accepted", got, cnt);
    endtask

    // Offer words base+idx on the K=4 chain until idx reaches upto or the
    // cycle budget runs out; leaves valid low afterwards.
    task automatic feed4(input logic [15:0] base, input int upto, input int max_cyc, inout int k);
        for (int i = 0; i < max_cyc && k < upto; i++) begin
            v4 = 1'b1; d4 = base + 16'(k);
            tick();
            if (acc4) k++;
        end
        v4 = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        v4 = 0; d4 = '0; or4 = 0;
        v3 = 0; d3 = '0; or3 = 0;
        v0 = 0; d0 = '0; or0 = 0;
        n4 = 0; n3 = 0; pops4 = 0; pops3 = 0; lat_on = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        or4 = 1'b1; or3 = 1'b1;
        #1;
        chk("rst_in_ready", ir4, 0);
        chk("rst_out_valid", ov4, 0);
        chk("rst_out_data", od4, 0);
        chk("rst_count", cnt4, 0);
        rst = 1'b0;
        tick();

        // K=3: same word twice, keys alternate A then B.
        lat_on = 1'b1;
        log3.delete();
        send3(16'h1234, 2);
        drain();
        chk("k3_words", log3.size(), 2);
        chk("k3_word0", log3[0], 16'h1D3B);
        chk("k3_word1", log3[1], 16'hE2C4);

        // K=4: eight words back to back, no bubbles, 4-cycle latency.
        idx = 0;
        feed4(16'hA000, 8, 8, idx);
        chk("stream_no_bubble", idx, 8);
        drain();
        chk("stream_count", cnt4, STATS ? 16'(pops4) : 16'h0);
        lat_on = 1'b0;

        // Backpressure: six offered, four held, oldest at the output.
        or4 = 1'b0;
        idx = 0;
        feed4(16'hB000, 6, 6, idx);
        chk("bp_accepted", idx, 4);
        v4 = 1'b1; d4 = 16'hB000 + 16'(idx);
        #1;
        chk("bp_in_ready_low", ir4, 0);
        chk("bp_out_valid", ov4, 1);
        chk("bp_out_word0", od4, 16'hB000);
        or4 = 1'b1;
        #1;
        chk("bp_in_ready_release", ir4, 1);
        feed4(16'hB000, 6, 10, idx);
        chk("bp_all_accepted", idx, 6);
        drain();
        chk("bp_count", cnt4, STATS ? 16'(pops4) : 16'h0);

        // Flush on a full chain with input and output both offered.
        send3(16'h3C3C, 3);
        drain();
        or4 = 1'b0;
        idx = 0;
        feed4(16'hC000, 4, 8, idx);
        chk("fl_filled", idx, 4);
        flush = 1'b1; v4 = 1'b1; d4 = 16'hDEAD; or4 = 1'b1;
        #1;
        chk("fl_in_refused", ir4, 0);
        chk("fl_in_refused_k3", ir3, 0);
        chk("fl_out_valid_kept", ov4, 1);
        tick();
        flush = 1'b0; v4 = 1'b0;
        #1;
        chk("fl_out_valid_next", ov4, 0);
        chk("fl_in_ready_after", ir4, 1);
        chk("fl_count_held", cnt4, STATS ? 16'(pops4) : 16'h0);
        log3.delete();
        send3(16'h5555, 1);
        drain();
        chk("fl_key_a", log3.size() == 1 ? log3[0] : 16'hXXXX, 16'h5A5A);

        // Asynchronous reset with words in flight.
        idx = 0;
        feed4(16'hE000, 3, 3, idx);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_out_valid", ov4, 0);
        chk("ar_out_data", od4, 0);
        chk("ar_in_ready", ir4, 0);
        chk("ar_count", cnt4, 0);
        chk("ar_out_valid_k3", ov3, 0);
        q4.delete(); q3.delete();
        n4 = 0; n3 = 0; pops4 = 0; pops3 = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        log3.delete();
        send3(16'h00FF, 2);
        drain();
        chk("ar_words", log3.size(), 2);
        chk("ar_key_a", log3[0], 16'h0FF0);
        chk("ar_key_b", log3[1], 16'hF00F);

        // K=0: combinational pass-through and counter saturation.
        v0 = 1'b1; or0 = 1'b1;
        d0 = 16'h1357; #1; chk("k0_data_a", od0, 16'h1357);
        d0 = 16'hFFFF; #1; chk("k0_data_b", od0, 16'hFFFF);
        chk("k0_valid", ov0, 1);
        or0 = 1'b0; #1; chk("k0_ready_low", ir0, 0);
        or0 = 1'b1; #1; chk("k0_ready_high", ir0, 1);
        v0 = 1'b0;
        @(posedge clk);
        #1;
        v0 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            d0 = 16'(i);
            tick();
            if (i == 13) chk("k0_count_14", cnt0, STATS ? 4'd14 : 4'd0);
        end
        v0 = 1'b0;
        chk("k0_count_sat", cnt0, STATS ? 4'hF : 4'h0);

        chk("end_q4_empty", q4.size(), 0);
        chk("end_q3_empty", q3.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
